scan_sel_gen: RTL
=================

// Module: scan_sel_gen
// PURPOSE
//  Sequential select generator that sits directly upstream of the 3-to-8 decoder.
//  Its sel[2:0] output drives the decoder's A input, stepping 0..LAST_IDX.
//  Each index is held for DWELL clocks, so the decoder's one-hot Y scans its 8 lines (display/row multiplexing).
//  Supports continuous scanning or a single sweep, with start/stop/pause control.
// PARAMETERS
//  DWELL     4  clocks each index is held; legal range 1..255
//  LAST_IDX  7  highest index issued, 0..7; scan covers 0..LAST_IDX
//  (local) CW = $clog2(DWELL+1), the dwell counter width
// PORTS
//  clk         in   1  system clock; all logic on its rising edge
//  rst         in   1  synchronous reset, active-high
//  start       in   1  1-cycle pulse that begins or restarts a scan at index 0
//  stop        in   1  1-cycle pulse that aborts the scan and returns to IDLE
//  en          in   1  1 = advance; 0 = freeze index and dwell counter (pause)
//  mode        in   1  0 = continuous wrap, 1 = single sweep; sampled only on an accepted start
//  sel         out  3  index to decoder A; forced to 3'b000 when not scanning
//  sel_valid   out  1  1 while sel is a live scan index (state SCAN)
//  wrap        out  1  1-cycle pulse on the LAST_IDX->0 transition in continuous mode
//  sweep_done  out  1  1-cycle pulse when a single sweep completes
//  busy        out  1  1 in SCAN or DONE
// BEHAVIOUR
//  Reset (rst=1 at a clk edge)
//   - state=IDLE, sel=0, dwell_cnt=0, mode_q=0.
//   - sel_valid=0, wrap=0, sweep_done=0, busy=0.
//   - rst overrides all other inputs.
//  FSM states: IDLE, SCAN, DONE.
//  IDLE
//   - start=1 & stop=0 -> SCAN next cycle, with sel=0, dwell_cnt=0, mode_q<=mode.
//  SCAN
//   - en=1: dwell_cnt increments each cycle.
//   - When dwell_cnt==DWELL-1: dwell_cnt<=0 and the index advances.
//   - Below LAST_IDX: sel<=sel+1.
//   - At LAST_IDX with mode_q=0: sel<=0 and wrap=1 for exactly that cycle; state stays SCAN.
//   - At LAST_IDX with mode_q=1: state -> DONE and sel<=0.
//   - en=0: sel and dwell_cnt hold and no pulses fire; en is ignored outside SCAN.
//  DONE
//   - sweep_done=1 for exactly one cycle, then the state goes to IDLE unconditionally.
//  Timing
//   - Outputs are registered: state/sel changes become visible the cycle after the triggering edge.
//   - Latency from start to sel_valid=1 is 1 clk.
//   - With en held high, each index is visible for exactly DWELL clocks.
//   - A full sweep takes (LAST_IDX+1)*DWELL clocks in SCAN.
//  Boundary conditions
//   - stop=1 in any state -> IDLE next cycle, sel=0, no pulses; stop wins over a simultaneous start.
//   - start=1 in SCAN (stop=0) restarts: sel=0, dwell_cnt=0, mode_q re-sampled, no wrap/done pulse.
//   - start=1 in DONE is ignored; the FSM still goes to IDLE.
//   - DWELL=1: sel advances every enabled cycle.
//   - LAST_IDX=0: sel stays 0; wrap pulses every DWELL enabled cycles in continuous mode.
//   - en=0 on the final dwell cycle delays the advance and its pulse until en returns to 1.
//   - rst mid-scan -> IDLE next cycle; no sweep_done is emitted.
//   - sel is never driven above LAST_IDX.
// TESTING
//  1. Reset with all inputs at 0 -> sel=0, sel_valid=busy=wrap=sweep_done=0, held over 10 clocks.
//  2. DWELL=4, LAST_IDX=7, mode=1, start pulse, en=1 ->
//     sel steps 0..7, each held 4 clocks; sweep_done pulses once, 33 clocks after start; then IDLE.
//  3. mode=0, en=1 -> sel goes 7->0; wrap pulses for 1 clock every 32 clocks; no sweep_done ever.
//  4. en=0 for 5 clocks while sel=3 at dwell_cnt=2 ->
//     sel stays 3 for a total of 9 clocks; the sequence then resumes to 4.
//  5. start and stop in the same cycle during SCAN with sel=5 ->
//     next cycle IDLE, sel=0, sel_valid=0, no pulses.
//  6. start during SCAN with sel=6, followed by rst asserted while sel=2 ->
//     restart shows sel=0 the next clock; rst gives IDLE/0 the next clock; no sweep_done.
//     Bench instantiates the decoder and checks Y == 8'b1 << sel whenever sel_valid=1.

Source files
------------

// File: rtl/scan_sel_gen_if.sv
// Control and select bus between the scan sequencer and its driver/observer.
// The master drives the scan controls; the slave (the sequencer) drives the decoder select and status.
interface scan_sel_gen_if;
  logic       start;
  logic       stop;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic       sel_valid;
  logic       wrap;
  logic       sweep_done;
  logic       busy;

  modport master (
    output start, stop, en, mode,
    input  sel, sel_valid, wrap, sweep_done, busy
  );

  modport slave (
    input  start, stop, en, mode,
    output sel, sel_valid, wrap, sweep_done, busy
  );
endinterface

// File: rtl/scan_sel_gen.sv
// Select generator feeding a 3-to-8 decoder: steps sel 0..LAST_IDX, holding each
// index DWELL clocks, in continuous-wrap or single-sweep mode.
module scan_sel_gen #(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned LAST_IDX = 7
) (
  input  logic          clk,
  input  logic          rst,
  scan_sel_gen_if.slave bus
);
  localparam int unsigned CW        = $clog2(DWELL + 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  localparam logic [2:0]    LAST_SEL  = 3'(LAST_IDX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [2:0]    sel_q;
  logic [CW-1:0] dwell_q;
  logic          mode_q;
  logic          sel_valid_q;
  logic          wrap_q;
  logic          done_q;
  logic          busy_q;

  // Sequencer: state, index, dwell counter and all status outputs registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      dwell_q     <= '0;
      mode_q      <= 1'b0;
      sel_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q     <= IDLE;
        sel_q       <= 3'd0;
        dwell_q     <= '0;
        sel_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q     <= SCAN;
              sel_q       <= 3'd0;
              dwell_q     <= '0;
              mode_q      <= bus.mode;
              sel_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
          SCAN: begin
            if (bus.start) begin
              sel_q   <= 3'd0;
              dwell_q <= '0;
              mode_q  <= bus.mode;
            end else if (bus.en) begin
              if (dwell_q == DWELL_END) begin
                dwell_q <= '0;
                // >= keeps sel bounded even if it were ever disturbed above LAST_IDX
                if (sel_q >= LAST_SEL) begin
                  sel_q <= 3'd0;
                  if (mode_q) begin
                    state_q     <= DONE;
                    sel_valid_q <= 1'b0;
                    done_q      <= 1'b1;
                  end else begin
                    wrap_q <= 1'b1;
                  end
                end else begin
                  sel_q <= sel_q + 3'd1;
                end
              end else begin
                dwell_q <= dwell_q + CW'(1);
              end
            end
          end
          DONE: begin
            state_q     <= IDLE;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
          default: begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            dwell_q     <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.sweep_done = done_q;
  assign bus.busy       = busy_q;
endmodule
